// File: rtl/work_deserializer_if.sv
// ---------------------------------------------------------------------------
// work_deserializer_if
// Bundles the serial work-loader signals and the published work word of the
// work deserializer.
//   load        : single-cycle frame-start strobe (loader -> deserializer)
//   din         : serial work bit, meaningful when shift=1
//   shift       : bit-valid qualifier for din
//   midstate    : last completed midstate field
//   nonce_init  : last completed initial-nonce field
//   data        : last completed header-tail data field
//   work_valid  : one-cycle pulse, a new frame has just been published
//   busy        : high while a frame is being received
//   overrun     : sticky flag, a bit arrived while no frame was open
// The master modport belongs to the work loader; slave to the deserializer.
// ---------------------------------------------------------------------------
interface work_deserializer_if #(
    parameter int MIDSTATE_W = 256,
    parameter int NONCE_W    = 32,
    parameter int DATA_W     = 96
);
    logic                  load;
    logic                  din;
    logic                  shift;
    logic [MIDSTATE_W-1:0] midstate;
    logic [NONCE_W-1:0]    nonce_init;
    logic [DATA_W-1:0]     data;
    logic                  work_valid;
    logic                  busy;
    logic                  overrun;

    modport master (
        output load, din, shift,
        input  midstate, nonce_init, data, work_valid, busy, overrun
    );

    modport slave (
        input  load, din, shift,
        output midstate, nonce_init, data, work_valid, busy, overrun
    );
endinterface

// File: rtl/work_deserializer.sv
// ---------------------------------------------------------------------------
// work_deserializer
// Collects a serial work frame (midstate, initial nonce, header-tail data,
// all MSB-first) into a shadow register and publishes it atomically to the
// output fields, so the hashing core never sees a half-written work word.
// Ports:
//   hash_clk : sole clock, rising edge
//   reset    : synchronous, active-high
//   wif      : work_deserializer_if.slave (load/din/shift in,
//              midstate/nonce_init/data/work_valid/busy/overrun out)
// ---------------------------------------------------------------------------
module work_deserializer #(
    parameter int MIDSTATE_W = 256,
    parameter int NONCE_W    = 32,
    parameter int DATA_W     = 96
) (
    input logic                hash_clk,
    input logic                reset,
    work_deserializer_if.slave wif
);

    localparam int F     = MIDSTATE_W + NONCE_W + DATA_W;
    localparam int CNT_W = $clog2(F + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [F-1:0]          shadow_q, shadow_d;
    logic                  pend_q, pend_d;
    logic                  overrun_q, overrun_d;
    logic                  valid_q, valid_d;
    logic [MIDSTATE_W-1:0] midstate_q, midstate_d;
    logic [NONCE_W-1:0]    nonce_q, nonce_d;
    logic [DATA_W-1:0]     data_q, data_d;

    // State, counter, shadow and published-field registers.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shadow_q   <= '0;
            pend_q     <= 1'b0;
            overrun_q  <= 1'b0;
            valid_q    <= 1'b0;
            midstate_q <= '0;
            nonce_q    <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            overrun_q  <= overrun_d;
            valid_q    <= valid_d;
            midstate_q <= midstate_d;
            nonce_q    <= nonce_d;
            data_q     <= data_d;
        end
    end

    // Next-state logic. The publish copy is driven only by pend_q and reads
    // the shadow before any new bit can land in it, so a load arriving on the
    // publish cycle still lets the finished frame out intact.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        pend_d     = 1'b0;
        overrun_d  = overrun_q;
        valid_d    = 1'b0;
        midstate_d = midstate_q;
        nonce_d    = nonce_q;
        data_d     = data_q;

        if (pend_q) begin
            {midstate_d, nonce_d, data_d} = shadow_q;
            valid_d = 1'b1;
        end

        if (wif.load) begin
            // load wins over a same-cycle shift; the partial frame is dropped
            state_d   = RECV;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (wif.shift) begin
            if (state_q == RECV) begin
                shadow_d = {shadow_q[F-2:0], wif.din};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(F - 1)) begin
                    state_d = IDLE;
                    pend_d  = 1'b1;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign wif.midstate   = midstate_q;
    assign wif.nonce_init = nonce_q;
    assign wif.data       = data_q;
    assign wif.work_valid = valid_q;
    assign wif.busy       = (state_q == RECV);
    assign wif.overrun    = overrun_q;

endmodule

// File: tb/tb_work_deserializer.sv
// ---------------------------------------------------------------------------
// tb_work_deserializer
// Randomized scoreboard bench for work_deserializer. The driver keeps a
// behavioural model (list of accepted bits, open-frame flag, overrun flag)
// and pushes each completed frame with the edge on which it must appear.
// An independent monitor pops on every work_valid pulse and checks the
// pulse timing, the published fields, and that the fields hold otherwise.
// ---------------------------------------------------------------------------
module tb_work_deserializer;

    localparam int MW = 256;
    localparam int NW = 32;
    localparam int DW = 96;
    localparam int F  = MW + NW + DW;

    typedef struct {
        logic [F-1:0] frame;
        int           due;
    } exp_t;

    logic hash_clk = 1'b0;
    logic reset    = 1'b1;

    work_deserializer_if #(.MIDSTATE_W(MW), .NONCE_W(NW), .DATA_W(DW)) wif ();

    work_deserializer #(.MIDSTATE_W(MW), .NONCE_W(NW), .DATA_W(DW)) dut (
        .hash_clk (hash_clk),
        .reset    (reset),
        .wif      (wif)
    );

    always #5 hash_clk = ~hash_clk;

    int edges = 0;
    always @(posedge hash_clk) edges <= edges + 1;

    int           n_cmp  = 0;
    int           n_err  = 0;
    bit           mon_en = 1'b0;
    exp_t         exp_q[$];
    logic [F-1:0] last_pub = '0;
    bit           m_busy = 1'b0;
    bit           m_ovr  = 1'b0;
    bit           m_bits[$];

    localparam logic [F-1:0] REF_FRAME = {
        256'h3171e6831d493f45254964259bc31bade1b5bb1ae3c327bc54073d19f0ea633b,
        32'hffbd9207,
        96'hffff001e11f35052d554469e
    };

    task automatic checkOutput(input string name, input logic [F-1:0] act,
                               input logic [F-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    // One clock of stimulus, followed by the reference-model update and the
    // per-cycle status checks.
    task automatic applyStimulus(input bit r, input bit l, input bit s, input bit d);
        logic [F-1:0] fr;
        exp_t         e;
        reset     = r;
        wif.load  = l;
        wif.shift = s;
        wif.din   = d;
        @(posedge hash_clk);
        #1;
        if (r) begin
            m_busy   = 1'b0;
            m_ovr    = 1'b0;
            m_bits.delete();
            exp_q.delete();
            last_pub = '0;
        end else if (l) begin
            m_busy = 1'b1;
            m_ovr  = 1'b0;
            m_bits.delete();
        end else if (s) begin
            if (m_busy) begin
                m_bits.push_back(d);
                if (m_bits.size() == F) begin
                    for (int i = 0; i < F; i++) fr[F-1-i] = m_bits[i];
                    e.frame = fr;
                    e.due   = edges + 1;
                    exp_q.push_back(e);
                    m_busy = 1'b0;
                    m_bits.delete();
                end
            end else begin
                m_ovr = 1'b1;
            end
        end
        if (mon_en) begin
            checkOutput("busy", F'(wif.busy), F'(m_busy));
            checkOutput("overrun", F'(wif.overrun), F'(m_ovr));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic sendFrame(input logic [F-1:0] fr, input int max_gap);
        for (int i = 0; i < F; i++) begin
            if (max_gap > 0) idle($urandom_range(1, max_gap));
            applyStimulus(1'b0, 1'b0, 1'b1, fr[F-1-i]);
        end
    endtask

    function automatic logic [F-1:0] randFrame();
        logic [F-1:0] fr;
        for (int i = 0; i < F / 32; i++) fr[i*32 +: 32] = $urandom;
        return fr;
    endfunction

    // Scoreboard monitor: sampled on the falling edge, away from updates.
    always @(negedge hash_clk) begin
        if (mon_en) begin
            if (wif.work_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("work_valid_unexpected", F'(wif.work_valid), F'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("pulse_edge", F'(edges), F'(e.due));
                    last_pub = e.frame;
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= edges) begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("work_valid_missed", F'(wif.work_valid), F'(1));
                last_pub = e.frame;
            end
            checkOutput("midstate", F'(wif.midstate), F'(last_pub[F-1 -: MW]));
            checkOutput("nonce_init", F'(wif.nonce_init), F'(last_pub[DW +: NW]));
            checkOutput("data", F'(wif.data), F'(last_pub[DW-1:0]));
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [F-1:0] ones;
        ones = '1;
        $display("[TB] start");

        // reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        idle(3);

        // back-to-back reference frame
        $display("[TB] back-to-back frame");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        sendFrame(REF_FRAME, 0);
        idle(4);

        // gapped reference frame
        $display("[TB] gapped frame");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        sendFrame(REF_FRAME, 20);
        idle(4);

        // abort after 200 bits, then all-ones frame
        $display("[TB] abort and restart");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        sendFrame(ones, 0);
        idle(3);

        // overrun after a completed frame, cleared by load
        $display("[TB] overrun");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
        idle(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

        // load on the publish cycle
        $display("[TB] load coincident with publish");
        sendFrame(randFrame(), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        sendFrame(randFrame(), 3);
        idle(4);

        // reset mid-frame
        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 84; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
        idle(4);

        // free-running random traffic
        $display("[TB] random traffic");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5000; i++) begin
            applyStimulus(1'b0,
                          ($urandom_range(0, 1499) == 0),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)));
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
